simplez_core_p: RTL and testbench

- Parametrised next-generation SIMPLEZ CPU core.
- Executes the full 8-instruction SIMPLEZ set, including BR, BZ, CLR and DEC.
- Talks to an external memory/peripheral fabric through a ready-handshake bus that supports wait states.
- Adds a resume-from-HALT input. Sits at top level between program RAM/peripheral decode and board I/O.

---
 rtl/simplez_core_p.sv | 122 ++++++++++++
 tb/tb_simplez_core_p.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_core_p.sv
// rtl/simplez_core_p.sv - SIMPLEZ CPU core with ready-handshake memory bus and resume-from-HALT
module simplez_core_p #(
    parameter int DATAW  = 12,
    parameter int ADDRW  = 9,
    parameter int RST_PC = 0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             stop,
    output logic [ADDRW-1:0] pc_o,
    output logic [DATAW-1:0] ac_o
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] cp_q, cp_d;
    logic [DATAW-1:0] ac_q, ac_d;
    // RI is held as its two meaningful fields; the bits between CD and CO are never used.
    logic [2:0]       co_q, co_d;
    logic [ADDRW-1:0] cd_q, cd_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            cp_q    <= ADDRW'(RST_PC);
            ac_q    <= '0;
            co_q    <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            cp_q    <= cp_d;
            ac_q    <= ac_d;
            co_q    <= co_d;
            cd_q    <= cd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cp_d    = cp_q;
        ac_d    = ac_q;
        co_d    = co_q;
        cd_d    = cd_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    co_d    = mem_rdata[DATAW-1 -: 3];
                    cd_d    = mem_rdata[ADDRW-1:0];
                    cp_d    = cp_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (co_q)
                    OP_BR:   cp_d = cd_q;
                    OP_BZ:   if (ac_q == '0) cp_d = cd_q;
                    OP_CLR:  ac_d = '0;
                    OP_DEC:  ac_d = ac_q - 1'b1;
                    OP_HALT: state_d = S_HALTED;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (mem_ready) begin
                    if (co_q == OP_LD)  ac_d = mem_rdata;
                    if (co_q == OP_ADD) ac_d = ac_q + mem_rdata;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (resume) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so requests are also qualified by rstn to stay quiet in reset.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        stop     = 1'b0;
        mem_addr = cp_q;
        case (state_q)
            S_FETCH:  mem_rd = rstn;
            S_EXEC: begin
                mem_addr = cd_q;
                mem_wr   = rstn && (co_q == OP_ST);
                mem_rd   = rstn && (co_q == OP_LD || co_q == OP_ADD);
            end
            S_HALTED: stop = 1'b1;
            default: ;
        endcase
    end

    assign mem_wdata = ac_q;
    assign pc_o      = cp_q;
    assign ac_o      = ac_q;

endmodule

// File: tb/tb_simplez_core_p.sv
// tb/tb_simplez_core_p.sv - scoreboard bench for simplez_core_p
module tb_simplez_core_p;
    localparam int DW = 12;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;
    logic          resume = 1'b0;
    logic          stop;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] ac_o;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            nwait = 0;
    int            wcnt;
    logic          rdy_junk = 1'b0;
    logic          mon_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;
    xfer_t xq[$];
    int    rq[$];

    simplez_core_p #(.DATAW(DW), .ADDRW(AW), .RST_PC(0)) dut (
        .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .resume(resume), .stop(stop), .pc_o(pc_o), .ac_o(ac_o)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = ((mem_rd || mem_wr) && (wcnt >= nwait)) || rdy_junk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                wcnt <= 0;
        else if ((mem_rd || mem_wr) && !mem_ready) wcnt <= wcnt + 1;
        else                                      wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'o%0o, expected 'o%0o", tag, got, exp);
        end
    endtask

    task automatic push_x(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        xq.push_back({wr, a, d});
    endtask

    // Bus monitor: pops expected transfers, checks wait-state stability, performs writes.
    logic          pw = 1'b0;
    logic [AW-1:0] pa;
    logic          prd;
    logic [DW-1:0] pd;
    xfer_t         me;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                pw = 1'b0;
            end else begin
                check("rd_wr_excl", 32'(mem_rd && mem_wr), 0);
                if (mon_en && pw) begin
                    check("wait_addr", 32'(mem_addr), 32'(pa));
                    check("wait_rd", 32'(mem_rd), 32'(prd));
                    check("wait_wdata", 32'(mem_wdata), 32'(pd));
                end
                if ((mem_rd || mem_wr) && mem_ready) begin
                    if (mon_en) begin
                        if (xq.size() == 0) begin
                            check("sb_extra_xfer", 1, 0);
                        end else begin
                            me = xq.pop_front();
                            check("xfer_addr", 32'(mem_addr), 32'(me.addr));
                            check("xfer_wr", 32'(mem_wr), 32'(me.wr));
                            if (me.wr) check("xfer_wdata", 32'(mem_wdata), 32'(me.data));
                        end
                    end
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                end
                pw  = (mem_rd || mem_wr) && !mem_ready;
                pa  = mem_addr;
                prd = mem_rd;
                pd  = mem_wdata;
            end
        end
    end

    task automatic do_reset();
        rstn     = 1'b0;
        resume   = 1'b0;
        rdy_junk = 1'b0;
        mon_en   = 1'b0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        xq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic go();
        rstn = 1'b1;
    endtask

    task automatic run_halt(input int maxc, output int cyc);
        cyc = 0;
        while (!stop && cyc < maxc) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!stop) check("halt_timeout", 0, 1);
        if (rq.size() >= 2) begin
            check("final_pc", 32'(pc_o), rq.pop_front());
            check("final_ac", 32'(ac_o), rq.pop_front());
        end else begin
            check("sb_result_missing", 0, 1);
        end
    endtask

    task automatic load_s1();
        mem[0]     = 12'o1100;
        mem[1]     = 12'o2101;
        mem[2]     = 12'o0102;
        mem[3]     = 12'o7000;
        mem[9'o100] = 12'd5;
        mem[9'o101] = 12'd7;
        push_x(0, 9'o000, 0); push_x(0, 9'o100, 0);
        push_x(0, 9'o001, 0); push_x(0, 9'o101, 0);
        push_x(0, 9'o002, 0); push_x(1, 9'o102, 12'd12);
        push_x(0, 9'o003, 0);
        rq.push_back(4); rq.push_back(12);
    endtask

    int cyc, t;

    initial begin
        // 1: reset state and the LD/ADD/ST/HALT program with zero wait states
        nwait = 0;
        do_reset();
        check("rst_stop", 32'(stop), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_pc", 32'(pc_o), 0);
        check("rst_ac", 32'(ac_o), 0);
        load_s1();
        mon_en = 1'b1;
        go();
        run_halt(200, cyc);
        check("s1_cycles", 32'(cyc), 11);
        check("s1_mem102", 32'(mem[9'o102]), 12);
        check("s1_sb_left", 32'(xq.size()), 0);

        // 3: same program with three wait states per transfer
        nwait = 3;
        do_reset();
        load_s1();
        mon_en = 1'b1;
        go();
        run_halt(400, cyc);
        check("s3_cycles", 32'(cyc), 11 + 3 * 7);
        check("s3_mem102", 32'(mem[9'o102]), 12);
        check("s3_sb_left", 32'(xq.size()), 0);
        nwait = 0;

        // 2a: CLR; DEC; BZ not taken; HALT
        do_reset();
        mem[0] = 12'o5000; mem[1] = 12'o6000; mem[2] = 12'o4010; mem[3] = 12'o7000;
        rq.push_back(4); rq.push_back('o7777);
        go();
        run_halt(200, cyc);

        // 2b: CLR; BZ taken
        do_reset();
        mem[0] = 12'o5000; mem[1] = 12'o4010; mem[9'o10] = 12'o7000;
        rq.push_back('o11); rq.push_back(0);
        go();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("s2_bz_taken_pc", 32'(pc_o), 'o10);
        check("s2_bz_fetch_addr", 32'(mem_addr), 'o10);
        run_halt(200, cyc);

        // 4: HALT at 5, ignored ready while halted, resume continues at 6
        do_reset();
        mem[0] = 12'o1100;
        for (int i = 1; i <= 4; i++) mem[i] = 12'o4020;
        mem[5] = 12'o7000; mem[6] = 12'o6000; mem[7] = 12'o7000;
        mem[9'o100] = 12'o55;
        rq.push_back(6); rq.push_back('o55);
        go();
        run_halt(200, cyc);
        rdy_junk = 1'b1;
        repeat (10) @(negedge clk);
        check("s4_halt_stop", 32'(stop), 1);
        check("s4_halt_pc", 32'(pc_o), 6);
        check("s4_halt_ac", 32'(ac_o), 'o55);
        check("s4_halt_rd", 32'(mem_rd), 0);
        rdy_junk = 1'b0;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("s4_resume_stop", 32'(stop), 0);
        check("s4_resume_addr", 32'(mem_addr), 6);
        check("s4_resume_rd", 32'(mem_rd), 1);
        rq.push_back(8); rq.push_back('o54);
        run_halt(200, cyc);

        // 5a: ADD wraps 0o7777 + 2 -> 1
        do_reset();
        mem[0] = 12'o1100; mem[1] = 12'o2101; mem[2] = 12'o7000;
        mem[9'o100] = 12'o7777; mem[9'o101] = 12'd2;
        rq.push_back(3); rq.push_back(1);
        go();
        run_halt(200, cyc);

        // 5b: BR 0o777, HALT there, CP wraps to 0
        do_reset();
        mem[0] = 12'o3777; mem[9'o777] = 12'o7000;
        rq.push_back(0); rq.push_back(0);
        go();
        run_halt(200, cyc);

        // 6: reset asserted during an ST wait state
        nwait = 6;
        do_reset();
        mem[0] = 12'o1100; mem[1] = 12'o0101; mem[9'o100] = 12'o1234;
        go();
        t = 0;
        while (!mem_wr && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("s6_st_wait_seen", 32'(mem_wr), 1);
        check("s6_ac_before", 32'(ac_o), 'o1234);
        #2;
        rstn = 1'b0;
        #1;
        check("s6_async_wr", 32'(mem_wr), 0);
        check("s6_async_rd", 32'(mem_rd), 0);
        check("s6_async_pc", 32'(pc_o), 0);
        check("s6_async_ac", 32'(ac_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("s6_refetch_rd", 32'(mem_rd), 1);
        check("s6_refetch_addr", 32'(mem_addr), 0);
        check("s6_no_write", 32'(mem[9'o101]), 0);
        nwait = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
